// File: rtl/mult32x32_arbiter.sv
// Round-robin arbiter sharing one 32x32 multiplier among N_REQ requesters.
// Handshake: req[i] is held with stable operands until ack[i] pulses (capture); done[i] pulses once with result valid.
module mult32x32_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     done,
    output logic [63:0]          result,
    output logic [IDW-1:0]       result_id,
    output logic                 arb_busy,
    output logic                 m_start,
    output logic [31:0]          m_a,
    output logic [31:0]          m_b,
    input  logic                 m_busy,
    input  logic [63:0]          m_product,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DELIVER   = 3'd4
    } state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] pick;
    logic           any_req;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;

    // Walk from the farthest index back to last_grant+1 so the nearest set bit is written last and wins.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        any_req = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[IDW'(idx)]) begin
                pick    = IDW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IDW'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    assign arb_busy  = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= IDW'(N_REQ - 1);
            win_id     <= '0;
            ack        <= '0;
            done       <= '0;
            m_start    <= 1'b0;
            m_a        <= '0;
            m_b        <= '0;
            result     <= '0;
            result_id  <= '0;
        end else begin
            ack     <= '0;
            done    <= '0;
            m_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_id     <= pick;
                        last_grant <= pick;
                        m_a        <= sel_a;
                        m_b        <= sel_b;
                        m_start    <= 1'b1;
                        ack        <= N_REQ'(1) << pick;
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (m_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!m_busy) begin
                        result    <= m_product;
                        result_id <= win_id;
                        done      <= N_REQ'(1) << win_id;
                        state     <= DELIVER;
                    end
                end
                DELIVER: begin
                    m_a   <= '0;
                    m_b   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult32x32_arbiter.md
MULT32X32_ARBITER -- requirements
Module: mult32x32_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one mult32x32; legal range 2..8.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 Port: req  in  N_REQ  level request per requester; held until that requester's ack.
REQ-005 Port: req_a  in  32*N_REQ  operand a per requester, slice i = bits [32i+31:32i].
REQ-006 Port: req_b  in  32*N_REQ  operand b per requester, same slicing.
REQ-007 Port: ack  out  N_REQ  one-cycle pulse; operands of requester i captured.
REQ-008 Port: done  out  N_REQ  one-cycle pulse; result valid for requester i.
REQ-009 Port: result  out  64  product of last completed job; holds until next completion.
REQ-010 Port: result_id  out  clog2(N_REQ)  index of requester owning result.
REQ-011 Port: arb_busy  out  1  high whenever state is not IDLE.
REQ-012 Port: m_start  out  1  start to multiplier.
REQ-013 Port: m_a, m_b  out  32 each  operands to multiplier.
REQ-014 Port: m_busy  in  1  multiplier busy.
REQ-015 Port: m_product  in  64  multiplier product, valid once m_busy falls.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DELIVER.
REQ-017 IDLE: if any req bit high, select winner, latch its operands and index, go to ISSUE; else stay.
REQ-018 Winner selection: round-robin; search starts at last_grant+1 modulo N_REQ; first set req bit wins.
REQ-019 last_grant updates to the winner on the IDLE->ISSUE transition only.
REQ-020 ISSUE lasts exactly one cycle: m_start=1, ack[winner]=1, m_a/m_b = latched operands; next WAIT_BUSY.
REQ-021 m_a/m_b hold latched operands from ISSUE through DELIVER; 0 in IDLE.
REQ-022 WAIT_BUSY: m_start=0; on m_busy=1 go to WAIT_DONE; else stay (multiplier raises busy 1 cycle after start).
REQ-023 WAIT_DONE: stay while m_busy=1; on m_busy=0 load result<=m_product, result_id<=winner, go to DELIVER.
REQ-024 DELIVER lasts one cycle: done[result_id]=1; next IDLE.
REQ-025 Minimum turnaround: req seen in IDLE -> done = 3 + multiplier busy duration cycles; next grant earliest 1 cycle after DELIVER.
REQ-026 req changes after ack are ignored until the FSM returns to IDLE; req_a/req_b changes after ack do not affect the in-flight job.
REQ-027 At most one bit of ack, at most one bit of done high in any cycle; never both for the same job in one cycle.
REQ-028 Product width: full 64-bit unsigned product passed through unmodified; no truncation.
REQ-029 A requester whose req stays high is re-served only after every other requesting index has been served once.

Reset
REQ-030 reset=0 asynchronously sets: state IDLE, ack=0, done=0, m_start=0, m_a=0, m_b=0, result=0, result_id=0, arb_busy=0.
REQ-031 reset sets last_grant=N_REQ-1 so requester 0 has first priority.
REQ-032 Reset mid-job abandons it: no done is issued for it; requester must re-request.
REQ-033 First grant possible on the first rising edge after reset returns to 1.

Verification
REQ-034 req[0]=1, a=3, b=5 -> ack[0] 1 cycle with m_start=1, m_a=3, m_b=5; later done[0] with result=15, result_id=0.
REQ-035 req=4'b1111 simultaneously, distinct operands -> acks/dones in order 0,1,2,3, each exactly once, each result correct.
REQ-036 req[0] and req[2] held high -> grant sequence 0,2,0,2; req[1], req[3] never acked.
REQ-037 a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE00000001; a=209728609, b=212015051 -> result=44465621733294059.
REQ-038 reset=0 during WAIT_DONE with req[1] pending -> all outputs 0 immediately, no done; after release, req[1] served with correct result.
REQ-039 Multiplier stub with busy duration 1 and 6 cycles -> done timing tracks m_busy fall per REQ-023/024, results correct.
